// File: rtl/rx_sample_if.sv
// Receiver-to-CPU sample path: sample strobe/data in, 16-bit word reads and status out.
interface rx_sample_if #(
  parameter int IN_WIDTH   = 24,
  parameter int DEPTH_LOG2 = 9
);
  logic                        in_avail;
  logic signed [IN_WIDTH-1:0]  in_i;
  logic signed [IN_WIDTH-1:0]  in_q;
  logic                        rd_strobe;
  logic                        clr_flags;
  logic [15:0]                 rd_data;
  logic [DEPTH_LOG2:0]         count;
  logic                        ready;
  logic                        full;
  logic                        overflow;
  logic                        underrun;

  modport master (
    output in_avail, in_i, in_q, rd_strobe, clr_flags,
    input  rd_data, count, ready, full, overflow, underrun
  );

  modport slave (
    input  in_avail, in_i, in_q, rd_strobe, clr_flags,
    output rd_data, count, ready, full, overflow, underrun
  );
endinterface

// File: rtl/rx_sample_fifo.sv
// Circular I/Q sample buffer in the ADC clock domain; each sample is read back
// as three 16-bit words: I[23:8], Q[23:8], {I[7:0], Q[7:0]}.
module rx_sample_fifo #(
  parameter int IN_WIDTH   = 24,
  parameter int DEPTH_LOG2 = 9,
  parameter int THRESH     = 170
) (
  input  logic        adc_clk,
  input  logic        reset_n,
  rx_sample_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] THRESH_C = THRESH[DEPTH_LOG2:0];

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } rd_state_e;

  logic [2*IN_WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]       wr_ptr;
  logic [DEPTH_LOG2-1:0]       rd_ptr;
  logic [DEPTH_LOG2:0]         count;
  logic [DEPTH_LOG2:0]         count_next;
  logic [1:0]                  word_idx;
  rd_state_e                   state;
  rd_state_e                   state_next;
  logic signed [IN_WIDTH-1:0]  head_i_p1;
  logic signed [IN_WIDTH-1:0]  head_q_p1;
  logic [15:0]                 rd_data;
  logic                        ready;
  logic                        full;
  logic                        overflow;
  logic                        underrun;
  logic                        wr_acc;
  logic                        wr_drop;
  logic                        rd_acc;
  logic                        rd_done;
  logic                        rd_bad;

  function automatic logic [15:0] word_sel(
    input logic [1:0]                 idx,
    input logic signed [IN_WIDTH-1:0] hi,
    input logic signed [IN_WIDTH-1:0] hq
  );
    case (idx)
      2'd0:    word_sel = hi[IN_WIDTH-1 -: 16];
      2'd1:    word_sel = hq[IN_WIDTH-1 -: 16];
      default: word_sel = {hi[7:0], hq[7:0]};
    endcase
  endfunction

  assign wr_acc  = bus.in_avail && !full;
  assign wr_drop = bus.in_avail && full;
  assign rd_acc  = bus.rd_strobe && (state == HOLD);
  assign rd_bad  = bus.rd_strobe && (state != HOLD);
  assign rd_done = rd_acc && (word_idx == 2'd2);

  // Occupancy includes the head sample until its third word has been served.
  always_comb begin
    count_next = count;
    case ({wr_acc, rd_done})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (count_next != '0) state_next = FETCH;
      FETCH:   state_next = HOLD;
      HOLD:    if (rd_done) state_next = (count_next != '0) ? FETCH : EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // p0 -> p1: sample RAM write and head fetch; write never targets the head
  // address because a full buffer blocks the write.
  always_ff @(posedge adc_clk) begin
    if (wr_acc) mem[wr_ptr] <= {bus.in_i, bus.in_q};
    if (state == FETCH) {head_i_p1, head_q_p1} <= mem[rd_ptr];
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      state    <= EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_idx <= '0;
      rd_data  <= '0;
      ready    <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      ready <= (count_next >= THRESH_C);
      full  <= (count_next == DEPTH_C);
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_done) rd_ptr <= rd_ptr + 1'b1;
      if (state == FETCH) begin
        word_idx <= '0;
      end else if (rd_acc) begin
        word_idx <= word_idx + 1'b1;
      end
      if (rd_acc) rd_data <= word_sel(word_idx, head_i_p1, head_q_p1);
      // A set event in the same cycle as the clear keeps the flag raised.
      if (wr_drop) begin
        overflow <= 1'b1;
      end else if (bus.clr_flags) begin
        overflow <= 1'b0;
      end
      if (rd_bad) begin
        underrun <= 1'b1;
      end else if (bus.clr_flags) begin
        underrun <= 1'b0;
      end
    end
  end

  assign bus.rd_data  = rd_data;
  assign bus.count    = count;
  assign bus.ready    = ready;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.underrun = underrun;

endmodule

// File: tb/tb_rx_sample_fifo.sv
// Directed bench for rx_sample_fifo: word ordering, full/overflow, threshold,
// streaming with pointer wrap, flag handling and mid-read reset.
module tb_rx_sample_fifo;

  logic adc_clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 adc_clk = ~adc_clk;

  rx_sample_if #(.IN_WIDTH(24), .DEPTH_LOG2(9)) bus ();

  rx_sample_fifo #(.IN_WIDTH(24), .DEPTH_LOG2(9), .THRESH(170)) dut (
    .adc_clk (adc_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  function automatic logic [23:0] gen_i(input int k);
    return 24'((k * 32'h0001_0203) ^ 32'h005A_5A5A);
  endfunction

  function automatic logic [23:0] gen_q(input int k);
    return 24'(32'h0080_0000 + k * 7);
  endfunction

  function automatic logic [15:0] exp_word(input int k, input int ph);
    logic [23:0] vi;
    logic [23:0] vq;
    vi = gen_i(k);
    vq = gen_q(k);
    if (ph == 0) return vi[23:8];
    if (ph == 1) return vq[23:8];
    return {vi[7:0], vq[7:0]};
  endfunction

  task automatic do_reset();
    bus.in_avail  = 1'b0;
    bus.rd_strobe = 1'b0;
    bus.clr_flags = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic write_sample(input logic [23:0] vi, input logic [23:0] vq);
    bus.in_i     = vi;
    bus.in_q     = vq;
    bus.in_avail = 1'b1;
    tick();
    bus.in_avail = 1'b0;
  endtask

  task automatic strobe(output logic [15:0] w);
    bus.rd_strobe = 1'b1;
    tick();
    bus.rd_strobe = 1'b0;
    w = bus.rd_data;
  endtask

  // One idle cycle lets the FSM leave FETCH, then three back-to-back strobes.
  task automatic read_sample(output logic [15:0] w0, output logic [15:0] w1, output logic [15:0] w2);
    tick();
    strobe(w0);
    strobe(w1);
    strobe(w2);
  endtask

  initial begin
    logic [15:0] w0, w1, w2;
    int max_cnt;
    int k;
    int ph;
    int n_stream;

    bus.in_avail  = 1'b0;
    bus.in_i      = '0;
    bus.in_q      = '0;
    bus.rd_strobe = 1'b0;
    bus.clr_flags = 1'b0;

    // Reset state and single-sample readout
    do_reset();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_flags", {28'd0, bus.ready, bus.full, bus.overflow, bus.underrun}, 0);
    write_sample(24'h123456, 24'hABCDEF);
    chk("one_count_up", 32'(bus.count), 1);
    read_sample(w0, w1, w2);
    chk("one_w0", 32'(w0), 32'h1234);
    chk("one_w1", 32'(w1), 32'hABCD);
    chk("one_w2", 32'(w2), 32'h56EF);
    chk("one_count_down", 32'(bus.count), 0);
    chk("one_no_underrun", 32'(bus.underrun), 0);

    // Fill to full, overflow, clear-vs-set priority, drain in order
    do_reset();
    for (int i = 0; i < 512; i++) write_sample(gen_i(i), gen_q(i));
    chk("fill_count", 32'(bus.count), 512);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_ready", 32'(bus.ready), 1);
    chk("fill_no_ovf", 32'(bus.overflow), 0);
    write_sample(gen_i(512), gen_q(512));
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 512);
    bus.clr_flags = 1'b1;
    write_sample(gen_i(513), gen_q(513));
    bus.clr_flags = 1'b0;
    chk("ovf_clr_coincident", 32'(bus.overflow), 1);
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    chk("ovf_clr_alone", 32'(bus.overflow), 0);
    for (int i = 0; i < 512; i++) begin
      read_sample(w0, w1, w2);
      chk("drain_w0", 32'(w0), 32'(exp_word(i, 0)));
      chk("drain_w1", 32'(w1), 32'(exp_word(i, 1)));
      chk("drain_w2", 32'(w2), 32'(exp_word(i, 2)));
    end
    chk("drain_count", 32'(bus.count), 0);
    chk("drain_full", 32'(bus.full), 0);
    tick();
    strobe(w0);
    chk("empty_underrun", 32'(bus.underrun), 1);
    chk("empty_rd_data_hold", 32'(w0), 32'(exp_word(511, 2)));
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    chk("clr_both", {30'd0, bus.overflow, bus.underrun}, 0);

    // Threshold crossing
    do_reset();
    for (int i = 0; i < 169; i++) write_sample(gen_i(i), gen_q(i));
    chk("thr_169_ready", 32'(bus.ready), 0);
    write_sample(gen_i(169), gen_q(169));
    chk("thr_170_count", 32'(bus.count), 170);
    chk("thr_170_ready", 32'(bus.ready), 1);
    read_sample(w0, w1, w2);
    chk("thr_read_count", 32'(bus.count), 169);
    chk("thr_read_ready", 32'(bus.ready), 0);

    // Streaming: one sample every 4th cycle, strobe every cycle. A sample
    // written in cycle 4k yields its words after cycles 4k+2, 4k+3, 4k+4.
    do_reset();
    n_stream = 1100;
    max_cnt = 0;
    for (int c = 0; c < 4 * n_stream + 4; c++) begin
      bus.in_avail  = ((c % 4) == 0) && (c / 4 < n_stream);
      bus.in_i      = gen_i(c / 4);
      bus.in_q      = gen_q(c / 4);
      bus.rd_strobe = 1'b1;
      tick();
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      if (c >= 2) begin
        k  = (c - 2) / 4;
        ph = (c - 2) % 4;
        if (ph < 3 && k < n_stream) chk("stream_word", 32'(bus.rd_data), 32'(exp_word(k, ph)));
      end
    end
    bus.in_avail  = 1'b0;
    bus.rd_strobe = 1'b0;
    chk("stream_no_ovf", 32'(bus.overflow), 0);
    chk("stream_cnt_bound", 32'(max_cnt <= 2), 1);
    chk("stream_end_count", 32'(bus.count), 0);

    // Reset in the middle of a head sample
    do_reset();
    strobe(w0);
    chk("mid_underrun_pre", 32'(bus.underrun), 1);
    write_sample(24'h111111, 24'h222222);
    write_sample(24'h333333, 24'h444444);
    tick();
    strobe(w0);
    strobe(w1);
    chk("mid_w1", 32'(w1), 32'h2222);
    do_reset();
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_rd_data", 32'(bus.rd_data), 0);
    chk("mid_rst_flags", {30'd0, bus.overflow, bus.underrun}, 0);
    write_sample(24'hFEDCBA, 24'h987654);
    read_sample(w0, w1, w2);
    chk("mid_new_w0", 32'(w0), 32'hFEDC);
    chk("mid_new_w1", 32'(w1), 32'h9876);
    chk("mid_new_w2", 32'(w2), 32'hBA54);
    chk("mid_new_count", 32'(bus.count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
